// File: rtl/scan_pkg.sv
// Shared types and constants for the scan sequencer.
package scan_pkg;

    localparam int unsigned SEL_W = 2;

    typedef enum logic {IDLE, SCAN} state_e;

    // Lowest set index of a 4-bit mask; returns 0 for an empty mask.
    function automatic logic [SEL_W-1:0] lowest_set(input logic [3:0] m);
        logic [SEL_W-1:0] r;
        r = '0;
        for (int i = 3; i >= 0; i--) begin
            if (m[i]) r = SEL_W'(i);
        end
        return r;
    endfunction

endpackage

// File: rtl/mask_next.sv
// Next set mask index strictly above the current one, wrapping to the lowest set index.
module mask_next
    import scan_pkg::*;
(
    input  logic [SEL_W-1:0] i_cur,
    input  logic [3:0]       i_mask,
    output logic [SEL_W-1:0] o_nxt,
    output logic             o_wrap
);

    always_comb begin
        o_nxt  = lowest_set(i_mask);
        o_wrap = 1'b1;
        // Descending scan so the last hit is the lowest index above i_cur.
        for (int i = 3; i >= 0; i--) begin
            if (i_mask[i] && (i > int'(i_cur))) begin
                o_nxt  = SEL_W'(i);
                o_wrap = 1'b0;
            end
        end
    end

endmodule

// File: rtl/scan_seq.sv
// Scan sequencer: steps a 2-to-4 decoder select through the active mask lines,
// holding each select for div+1 cycles and pulsing frame_done on every wrap.
module scan_seq
    import scan_pkg::*;
#(
    parameter int unsigned DIV_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic [DIV_W-1:0] div,
    input  logic [3:0]       mask,
    output logic             a,
    output logic             b,
    output logic             valid,
    output logic             frame_done
);

    state_e           r_state, w_state_d;
    logic [DIV_W-1:0] r_cnt, w_cnt_d;
    logic [DIV_W-1:0] r_div, w_div_d;
    logic [SEL_W-1:0] r_idx, w_idx_d;
    logic             r_fd, w_fd_d;
    logic [SEL_W-1:0] w_nxt;
    logic             w_wrap;

    mask_next u_mask_next (
        .i_cur  (r_idx),
        .i_mask (mask),
        .o_nxt  (w_nxt),
        .o_wrap (w_wrap)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
            r_cnt   <= '0;
            r_div   <= '0;
            r_idx   <= '0;
            r_fd    <= 1'b0;
        end else begin
            r_state <= w_state_d;
            r_cnt   <= w_cnt_d;
            r_div   <= w_div_d;
            r_idx   <= w_idx_d;
            r_fd    <= w_fd_d;
        end
    end

    always_comb begin
        w_state_d = r_state;
        w_cnt_d   = r_cnt;
        w_div_d   = r_div;
        w_idx_d   = r_idx;
        w_fd_d    = 1'b0;
        unique case (r_state)
            IDLE: begin
                w_cnt_d = '0;
                w_idx_d = '0;
                if (en && (mask != 4'h0)) begin
                    w_state_d = SCAN;
                    w_idx_d   = lowest_set(mask);
                    w_div_d   = div;
                end
            end
            SCAN: begin
                if (!en) begin
                    w_state_d = IDLE;
                    w_cnt_d   = '0;
                    w_idx_d   = '0;
                end else if (r_cnt == r_div) begin
                    w_cnt_d = '0;
                    if (mask == 4'h0) begin
                        w_state_d = IDLE;
                        w_idx_d   = '0;
                    end else begin
                        w_idx_d = w_nxt;
                        w_div_d = div;
                        w_fd_d  = w_wrap;
                    end
                end else begin
                    w_cnt_d = r_cnt + DIV_W'(1);
                end
            end
            default: begin
                w_state_d = IDLE;
                w_cnt_d   = '0;
                w_idx_d   = '0;
            end
        endcase
    end

    assign a          = r_idx[1];
    assign b          = r_idx[0];
    assign valid      = (r_state == SCAN);
    assign frame_done = r_fd;

endmodule

// File: tb/tb_scan_seq.sv
// Self-checking bench for scan_seq: directed scenarios plus randomized traffic
// compared against a dwell-countdown reference model.
module tb_scan_seq;

    localparam int unsigned DIV_W = 8;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             en = 1'b0;
    logic [DIV_W-1:0] div = '0;
    logic [3:0]       mask = '0;
    logic             a, b, valid, frame_done;

    int errors = 0;
    int checks = 0;

    // Reference model: active flag, shown index, cycles left in the current dwell.
    bit m_act = 1'b0;
    int m_idx = 0;
    int m_left = 0;
    bit m_fd = 1'b0;

    logic [3:0] got, want;

    scan_seq #(.DIV_W(DIV_W)) dut (
        .clk        (clk),
        .rst        (rst),
        .en         (en),
        .div        (div),
        .mask       (mask),
        .a          (a),
        .b          (b),
        .valid      (valid),
        .frame_done (frame_done)
    );

    always #5 clk = ~clk;

    function automatic int lowest(input logic [3:0] m);
        for (int i = 0; i < 4; i++) if (m[i]) return i;
        return 0;
    endfunction

    // One clock: model consumes the inputs present at the edge, outputs sampled 1 ns later.
    task automatic tick();
        bit n_act, n_fd;
        int n_idx, n_left;
        n_act = m_act; n_idx = m_idx; n_left = m_left; n_fd = 1'b0;
        if (rst) begin
            n_act = 1'b0; n_idx = 0; n_left = 0;
        end else if (!m_act) begin
            if (en && mask != 4'h0) begin
                n_act = 1'b1; n_idx = lowest(mask); n_left = int'(div);
            end
        end else if (!en) begin
            n_act = 1'b0; n_idx = 0;
        end else if (m_left > 0) begin
            n_left = m_left - 1;
        end else if (mask == 4'h0) begin
            n_act = 1'b0; n_idx = 0;
        end else begin
            for (int k = 1; k <= 4; k++) begin
                if (mask[(m_idx + k) % 4]) begin
                    n_idx = (m_idx + k) % 4;
                    break;
                end
            end
            n_fd = (n_idx <= m_idx);
            n_left = int'(div);
        end
        @(posedge clk);
        m_act = n_act; m_idx = n_idx; m_left = n_left; m_fd = n_fd;
        #1;
        got  = {a, b, valid, frame_done};
        want = {2'(m_idx), m_act, m_fd};
    endtask

    task automatic do_reset();
        rst = 1'b1; en = 1'b0;
        tick();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; en = 1'b1; mask = 4'hF; div = 8'd3;
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++;
            if (got !== 4'b0000) begin
                errors++; $display("FAIL reset_hold cyc%0d got=%b want=0000", i, got);
            end
        end
        rst = 1'b0;
        tick();
        checks++;
        if (got !== 4'b0010) begin
            errors++; $display("FAIL reset_release got=%b want=0010", got);
        end
    endtask

    task automatic test_full_mask();
        logic [3:0] exp;
        do_reset();
        en = 1'b1; mask = 4'hF; div = 8'd1;
        for (int i = 0; i < 18; i++) begin
            tick();
            exp = {2'((i / 2) % 4), 1'b1, (i == 8 || i == 16)};
            checks++;
            if (got !== exp) begin
                errors++; $display("FAIL full_mask cyc%0d got=%b want=%b", i, got, exp);
            end
            checks++;
            if (got !== want) begin
                errors++; $display("FAIL full_mask_model cyc%0d got=%b want=%b", i, got, want);
            end
        end
    endtask

    task automatic test_alternate();
        logic [3:0] exp;
        do_reset();
        en = 1'b1; mask = 4'b1010; div = 8'd0;
        for (int i = 0; i < 8; i++) begin
            tick();
            exp = {(i % 2 == 0) ? 2'd1 : 2'd3, 1'b1, (i % 2 == 0) && (i > 0)};
            checks++;
            if (got !== exp) begin
                errors++; $display("FAIL alternate cyc%0d got=%b want=%b", i, got, exp);
            end
        end
    endtask

    task automatic test_single();
        logic [3:0] exp;
        do_reset();
        en = 1'b1; mask = 4'b0100; div = 8'd2;
        for (int i = 0; i < 10; i++) begin
            tick();
            exp = {2'd2, 1'b1, (i % 3 == 0) && (i > 0)};
            checks++;
            if (got !== exp) begin
                errors++; $display("FAIL single cyc%0d got=%b want=%b", i, got, exp);
            end
        end
    endtask

    task automatic test_mask_drop();
        logic [3:0] exp;
        do_reset();
        en = 1'b1; mask = 4'hF; div = 8'd4;
        for (int i = 0; i < 8; i++) begin
            tick();
            exp = (i < 5) ? 4'b0010 : 4'b0000;
            checks++;
            if (got !== exp) begin
                errors++; $display("FAIL mask_drop cyc%0d got=%b want=%b", i, got, exp);
            end
            if (i == 1) mask = 4'h0;
        end
    endtask

    task automatic test_en_drop();
        logic [3:0] exp;
        do_reset();
        en = 1'b1; mask = 4'hF; div = 8'd5;
        for (int i = 0; i < 3; i++) tick();
        en = 1'b0;
        for (int i = 0; i < 2; i++) begin
            tick();
            checks++;
            if (got !== 4'b0000) begin
                errors++; $display("FAIL en_drop cyc%0d got=%b want=0000", i, got);
            end
        end
        en = 1'b1; mask = 4'b0110;
        for (int j = 0; j < 7; j++) begin
            tick();
            exp = {(j < 6) ? 2'd1 : 2'd2, 1'b1, 1'b0};
            checks++;
            if (got !== exp) begin
                errors++; $display("FAIL en_restart cyc%0d got=%b want=%b", j, got, exp);
            end
        end
    endtask

    task automatic test_rst_mid();
        do_reset();
        en = 1'b1; mask = 4'hF; div = 8'd3;
        for (int i = 0; i < 6; i++) tick();
        rst = 1'b1;
        tick();
        checks++;
        if (got !== 4'b0000) begin
            errors++; $display("FAIL rst_mid got=%b want=0000", got);
        end
        rst = 1'b0;
        tick();
        checks++;
        if (got !== 4'b0010) begin
            errors++; $display("FAIL rst_mid_restart got=%b want=0010", got);
        end
    endtask

    task automatic test_random();
        do_reset();
        for (int i = 0; i < 600; i++) begin
            rst = ($urandom_range(0, 59) == 0);
            en  = ($urandom_range(0, 11) != 0);
            if ($urandom_range(0, 5) == 0) mask = 4'($urandom_range(0, 15));
            div = DIV_W'($urandom_range(0, 3));
            tick();
            checks++;
            if (got !== want) begin
                errors++; $display("FAIL random cyc%0d got=%b want=%b", i, got, want);
            end
        end
        rst = 1'b0;
    endtask

    initial begin
        test_reset();
        test_full_mask();
        test_alternate();
        test_single();
        test_mask_drop();
        test_en_drop();
        test_rst_mid();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/scan_seq.md
SCAN_SEQ -- requirements
Module: scan_seq

Interface
REQ-001 Parameter DIV_W, default 8, width of the dwell-count input and internal counter.
REQ-002 clk  input  1  Single clock; all state updates on its rising edge.
REQ-003 rst  input  1  Reset, synchronous and active-high.
REQ-004 en  input  1  Scan enable; level-sensitive.
REQ-005 div  input  DIV_W  Dwell length minus one, in clk cycles per select value.
REQ-006 mask  input  4  Active-line mask; bit i set means decoder output yi is part of the scan.
REQ-007 a  output  1  Select MSB to downstream 2-to-4 decoder; index = {a,b}.
REQ-008 b  output  1  Select LSB to downstream 2-to-4 decoder.
REQ-009 valid  output  1  High while {a,b} is a live scan index.
REQ-010 frame_done  output  1  One-cycle pulse when the scan wraps past its highest active index.

Function
REQ-011 The block SHALL implement a two-state FSM: IDLE and SCAN.
REQ-012 In IDLE: valid=0, frame_done=0, {a,b}=2'b00, dwell counter=0.
REQ-013 IDLE->SCAN SHALL occur on the edge where en=1 and mask!=0; on that edge {a,b} loads the lowest set index of mask, div is latched, and counter clears; valid=1 from the next cycle.
REQ-014 In SCAN the counter SHALL increment each cycle; when counter equals latched div, an advance occurs on that edge.
REQ-015 On advance: {a,b} SHALL load the next set mask index strictly above the current one, wrapping circularly to the lowest set index; counter clears; div is re-latched.
REQ-016 Each select value SHALL therefore be held for exactly div+1 cycles; div=0 gives a one-cycle dwell.
REQ-017 frame_done SHALL be 1 for exactly the cycle after an advance whose new index is less than or equal to the old index (wrap), else 0.
REQ-018 With a single mask bit set, each advance SHALL reload the same index and pulse frame_done.
REQ-019 mask and div SHALL be sampled only at IDLE->SCAN entry and at advances; changes mid-dwell have no effect until the next advance.
REQ-020 If mask==0 at an advance, the FSM SHALL go to IDLE on that edge (no frame_done pulse).
REQ-021 en=0 in SCAN SHALL force IDLE on the next edge regardless of counter, with IDLE output values from the following cycle; en=1 with mask==0 keeps IDLE.
REQ-022 The counter SHALL never exceed latched div; no arithmetic overflow is possible.

Reset
REQ-023 rst=1 at a clock edge SHALL place the FSM in IDLE, clear counter and latched div, and drive a=0, b=0, valid=0, frame_done=0, overriding en, including mid-dwell.
REQ-024 After rst deasserts, a new scan SHALL begin only per REQ-013.

Structure
REQ-025 A shared package scan_pkg SHALL hold the state enum (IDLE, SCAN) and the select-width constant (2).
REQ-026 One combinational sub-module mask_next SHALL compute, from current index and mask, the next circular set index and a wrap flag.
REQ-027 All outputs SHALL be registered; no combinational path from inputs to outputs.

Verification
REQ-028 rst pulse mid-SCAN with div=3, mask=4'hF -> next cycle a=0,b=0,valid=0,frame_done=0.
REQ-029 en=1, mask=4'hF, div=1 -> {a,b} sequence 0,0,1,1,2,2,3,3,0..., valid=1, frame_done high on first cycle of each return to 0.
REQ-030 mask=4'b1010, div=0 -> {a,b} alternates 1,3,1,3; frame_done high each cycle showing 1 after 3.
REQ-031 mask=4'b0100, div=2 -> {a,b}=2 constant, frame_done one cycle in every 3.
REQ-032 mask changed 4'hF->4'h0 mid-dwell with div=4 -> index held until dwell ends, then valid=0 next cycle, no frame_done.
REQ-033 en dropped at counter=2 of div=5 -> valid=0 and {a,b}=0 one cycle later; re-enable restarts at lowest set index with full dwell.
